// File: rtl/u_dly_coarse_ctrl.sv
// Coarse delay-line tap controller: acquires the tap by sweeping upward from 0
// on a majority-style phase-detector vote, then tracks drift +/-1 tap with
// hysteresis. Every tap decision is followed by a settle wait before sampling.
module u_dly_coarse_ctrl #(
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned NSAMP      = 16,
    parameter int unsigned THR        = 4
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_en,
    input  logic       i_start,
    input  logic       i_pd_early,
    output logic [1:0] o_sel,
    output logic       o_lock,
    output logic       o_busy,
    output logic       o_sat
);

    localparam int unsigned EW   = $clog2(NSAMP + 1);
    localparam int unsigned CMAX = (SETTLE_CYC > NSAMP) ? SETTLE_CYC : NSAMP;
    localparam int unsigned CW   = $clog2(CMAX);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DECIDE = 2'd3;

    localparam logic MODE_ACQ = 1'b0;
    localparam logic MODE_TRK = 1'b1;

    localparam logic [EW-1:0] EARLY_TH    = EW'(NSAMP - THR);
    localparam logic [EW-1:0] LATE_TH     = EW'(THR);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] SAMP_LAST   = CW'(NSAMP - 1);

    logic [1:0]    state;
    logic          mode;
    logic [CW-1:0] cnt;
    logic [EW-1:0] e_cnt;
    logic          vote_early;
    logic          vote_late;

    // Classify the completed vote window against the hysteresis thresholds
    always_comb begin
        vote_early = (e_cnt >= EARLY_TH);
        vote_late  = (e_cnt <= LATE_TH);
    end

    // Control FSM: enable/start overrides, settle/sample sequencing, tap decisions
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state  <= ST_IDLE;
            mode   <= MODE_ACQ;
            cnt    <= '0;
            e_cnt  <= '0;
            o_sel  <= '0;
            o_lock <= 1'b0;
            o_busy <= 1'b0;
            o_sat  <= 1'b0;
        end else if (!i_en) begin
            // Disable wins over start; tap and saturation flag are retained
            state  <= ST_IDLE;
            o_busy <= 1'b0;
            o_lock <= 1'b0;
        end else if (i_start) begin
            // Start from IDLE and abort while busy share the same restart
            state  <= ST_SETTLE;
            o_busy <= 1'b1;
            mode   <= MODE_ACQ;
            cnt    <= '0;
            e_cnt  <= '0;
            o_sel  <= '0;
            o_lock <= 1'b0;
            o_sat  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_busy <= 1'b0;
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        e_cnt <= '0;
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    e_cnt <= e_cnt + EW'(i_pd_early);
                    if (cnt == SAMP_LAST) begin
                        cnt   <= '0;
                        state <= ST_DECIDE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DECIDE: begin
                    state <= ST_SETTLE;
                    cnt   <= '0;
                    if (mode == MODE_ACQ) begin
                        if (vote_early && (o_sel != 2'd3)) begin
                            o_sel <= o_sel + 2'd1;
                            o_sat <= 1'b0;
                        end else if (vote_early) begin
                            o_sat  <= 1'b1;
                            o_lock <= 1'b1;
                            mode   <= MODE_TRK;
                        end else begin
                            o_sat  <= 1'b0;
                            o_lock <= 1'b1;
                            mode   <= MODE_TRK;
                        end
                    end else begin
                        if (vote_early) begin
                            if (o_sel != 2'd3) begin
                                o_sel <= o_sel + 2'd1;
                                o_sat <= 1'b0;
                            end else begin
                                o_sat <= 1'b1;
                            end
                        end else if (vote_late) begin
                            if (o_sel != 2'd0) begin
                                o_sel <= o_sel - 2'd1;
                                o_sat <= 1'b0;
                            end else begin
                                o_sat <= 1'b1;
                            end
                        end else begin
                            o_sat <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_u_dly_coarse_ctrl.sv
// Directed bench for u_dly_coarse_ctrl at default parameters (period 25 cycles).
module tb_u_dly_coarse_ctrl;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       start;
    logic       pd;
    logic [1:0] sel;
    logic       lock;
    logic       busy;
    logic       sat;

    int errors = 0;
    int checks = 0;

    u_dly_coarse_ctrl #(
        .SETTLE_CYC (8),
        .NSAMP      (16),
        .THR        (4)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_en       (en),
        .i_start    (start),
        .i_pd_early (pd),
        .o_sel      (sel),
        .o_lock     (lock),
        .o_busy     (busy),
        .o_sat      (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int e_sel, input int e_lock,
                           input int e_busy, input int e_sat);
        chk({tag, ".sel"},  int'(sel),  e_sel);
        chk({tag, ".lock"}, int'(lock), e_lock);
        chk({tag, ".busy"}, int'(busy), e_busy);
        chk({tag, ".sat"},  int'(sat),  e_sat);
    endtask

    // Pulse start; returns 1 time unit after the edge that samples it (edge k)
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // One full iteration from just after edge k: pd high on the first e_tgt of
    // the 16 sampling edges (k+9..k+24); returns just after decision edge k+25
    task automatic iter(input int e_tgt);
        pd = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            pd = (i < e_tgt);
            @(posedge clk);
            #1;
        end
        pd = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn  = 1'b0;
        en    = 1'b0;
        start = 1'b0;
        pd    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0);
        rstn = 1'b1;
        en   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_out("idle_after_reset", 0, 0, 0, 0);

        // T2 acquire to tap 2
        do_start();
        chk_out("t2_start", 0, 0, 1, 0);
        iter(16);
        chk_out("t2_p1", 1, 0, 1, 0);
        iter(16);
        chk_out("t2_p2", 2, 0, 1, 0);
        iter(0);
        chk_out("t2_lock", 2, 1, 1, 0);

        // T5 track down from tap 2 to saturation at 0, then recover
        iter(0);
        chk_out("t5_down1", 1, 1, 1, 0);
        iter(0);
        chk_out("t5_down0", 0, 1, 1, 0);
        iter(0);
        chk_out("t5_sat0", 0, 1, 1, 1);
        iter(8);
        chk_out("t5_inwin", 0, 1, 1, 0);

        // T3 saturate high (restart while busy)
        do_start();
        chk_out("t3_start", 0, 0, 1, 0);
        iter(16);
        chk_out("t3_p1", 1, 0, 1, 0);
        iter(16);
        chk_out("t3_p2", 2, 0, 1, 0);
        iter(16);
        chk_out("t3_p3", 3, 0, 1, 0);
        iter(16);
        chk_out("t3_satlock", 3, 1, 1, 1);
        iter(16);
        chk_out("t3_trk_sat", 3, 1, 1, 1);

        // Disable while locked: lock drops, tap and sat held
        en = 1'b0;
        @(posedge clk);
        #1;
        chk_out("dis_locked", 3, 0, 0, 1);
        en = 1'b1;
        @(posedge clk);
        #1;

        // T4 hysteresis and threshold boundaries
        do_start();
        chk_out("t4_start", 0, 0, 1, 0);
        iter(10);
        chk_out("t4_lock", 0, 1, 1, 0);
        iter(5);
        chk_out("t4_e5", 0, 1, 1, 0);
        iter(11);
        chk_out("t4_e11", 0, 1, 1, 0);
        iter(12);
        chk_out("t4_e12_up", 1, 1, 1, 0);
        iter(4);
        chk_out("t4_e4_down", 0, 1, 1, 0);
        iter(5);
        chk_out("t4_e5_hold", 0, 1, 1, 0);

        // T6 abort mid-SAMPLE at tap 2
        do_start();
        iter(16);
        iter(16);
        chk_out("t6_pre", 2, 0, 1, 0);
        pd = 1'b1;
        repeat (13) @(posedge clk);
        #1;
        do_start();
        pd = 1'b0;
        chk_out("t6_abort", 0, 0, 1, 0);
        iter(16);
        chk_out("t6_restart", 1, 0, 1, 0);

        en    = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk_out("t6_en_wins", 1, 0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        chk_out("t6_idle", 1, 0, 0, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk_out("start_en0_ignored", 1, 0, 0, 0);
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_out("idle_no_start", 1, 0, 0, 0);

        // T1 asynchronous reset mid-run
        do_start();
        iter(16);
        chk_out("t1_pre", 1, 0, 1, 0);
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk_out("t1_async", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk_out("t1_idle", 0, 0, 0, 0);
        do_start();
        chk_out("t1_restart", 0, 0, 1, 0);
        iter(16);
        chk_out("t1_p1", 1, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
